// File: rtl/dm_bhw_if.sv
// dm_bhw_if: request/response bundle for the dm_bhw data memory.
//   master : requester (CPU memory stage, bridge, testbench)
//   slave  : the memory itself
// Signals:
//   req_valid/req_ready  request handshake, accepted when both are high at a rising edge
//   req_we               1 = store, 0 = load
//   req_size             00 byte, 01 half, 10 word, 11 illegal
//   req_sext             sign-extend loads (byte/half only)
//   req_addr             byte address
//   req_wdata            store data, right-justified
//   resp_valid           one-cycle response strobe
//   resp_rdata           extended load result (0 for stores and errors)
//   resp_err             misaligned or illegal request
interface dm_bhw_if #(
  parameter int ADDR_W = 14
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_sext;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_we, req_size, req_sext, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_sext, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dm_bhw.sv
// dm_bhw: byte/half/word data memory with a valid/ready request port and a
// fixed response latency (LATENCY = 1..4 cycles after acceptance).
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset; clears memory, FSM and outputs
//   bus    dm_bhw_if.slave request/response bundle
// Memory is 2^(ADDR_W-2) little-endian 32-bit words. Stores write only the
// addressed byte lanes; loads read at acceptance and are extended on output.
module dm_bhw #(
  parameter int ADDR_W  = 14,
  parameter int LATENCY = 1
) (
  input  logic     clk,
  input  logic     reset,
  dm_bhw_if.slave  bus
);

  localparam int IDX_W = ADDR_W - 2;
  localparam int DEPTH = 1 << IDX_W;
  localparam logic [1:0] CNT_LOAD = 2'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic [1:0] cnt_q, cnt_d;

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic accept;
  logic resp_valid;

  assign resp_valid    = (state_q == S_RESP);
  assign bus.req_ready = !reset && ((state_q == S_IDLE) || (state_q == S_RESP));
  assign accept        = bus.req_valid && bus.req_ready;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] idx;
  logic [1:0]       lane;
  logic             req_err;
  logic [3:0]       be_lane;
  logic [31:0]      wd_rep;
  logic [31:0]      lane_mask;
  logic [31:0]      wr_data;
  logic [3:0]       be_eff;
  logic             mem_we;

  assign idx  = bus.req_addr[ADDR_W-1:2];
  assign lane = bus.req_addr[1:0];

  always_comb begin
    req_err = 1'b0;
    be_lane = 4'b0000;
    wd_rep  = bus.req_wdata;
    case (bus.req_size)
      2'b00: begin
        be_lane = 4'b0001 << lane;
        wd_rep  = {4{bus.req_wdata[7:0]}};
      end
      2'b01: begin
        req_err = lane[0];
        be_lane = lane[1] ? 4'b1100 : 4'b0011;
        wd_rep  = {2{bus.req_wdata[15:0]}};
      end
      2'b10: begin
        req_err = (lane != 2'b00);
        be_lane = 4'b1111;
      end
      default: begin
        req_err = 1'b1;
      end
    endcase
  end

  // Expand byte enables to a bit mask so unaddressed lanes carry zeros.
  for (genvar gi = 0; gi < 4; gi++) begin : g_mask
    assign lane_mask[8*gi +: 8] = {8{be_lane[gi]}};
  end

  assign wr_data = wd_rep & lane_mask;
  assign mem_we  = accept && bus.req_we && !req_err;

  // ---------------------------------------------------------------------------
  // Per-word "written since reset" flags. Reset clears these instead of the
  // RAM, so the RAM itself can stay a plain inferred block RAM. A word whose
  // flag is clear reads as zero; the first store into it writes all four
  // lanes (zeros in the unaddressed ones) so the flag can then be trusted.
  // ---------------------------------------------------------------------------
  logic [DEPTH-1:0] wvalid_q, wvalid_d;

  always_comb begin
    wvalid_d = wvalid_q;
    if (mem_we) begin
      wvalid_d[idx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wvalid_q <= '0;
    end else begin
      wvalid_q <= wvalid_d;
    end
  end

  assign be_eff = wvalid_q[idx] ? be_lane : 4'b1111;

  // ---------------------------------------------------------------------------
  // Word RAM with byte-lane writes and a registered read taken at acceptance.
  // A load never shares an edge with a store, so read-during-write ordering
  // does not matter; a store one edge earlier is already in the array.
  // ---------------------------------------------------------------------------
  logic [31:0] mem [DEPTH];
  logic [31:0] rd_word_q;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be_eff[b]) begin
          mem[idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
    if (accept) begin
      rd_word_q <= mem[idx];
    end
  end

  // ---------------------------------------------------------------------------
  // Request attributes captured at acceptance for the output formatter.
  // ---------------------------------------------------------------------------
  logic       ld_q, ld_d;
  logic       err_q, err_d;
  logic [1:0] size_q, size_d;
  logic [1:0] lane_q, lane_d;
  logic       sext_q, sext_d;
  logic       hit_q, hit_d;

  always_comb begin
    ld_d   = ld_q;
    err_d  = err_q;
    size_d = size_q;
    lane_d = lane_q;
    sext_d = sext_q;
    hit_d  = hit_q;
    if (accept) begin
      ld_d   = !bus.req_we && !req_err;
      err_d  = req_err;
      size_d = bus.req_size;
      lane_d = lane;
      sext_d = bus.req_sext;
      hit_d  = wvalid_q[idx];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ld_q   <= 1'b0;
      err_q  <= 1'b0;
      size_q <= 2'b00;
      lane_q <= 2'b00;
      sext_q <= 1'b0;
      hit_q  <= 1'b0;
    end else begin
      ld_q   <= ld_d;
      err_q  <= err_d;
      size_q <= size_d;
      lane_q <= lane_d;
      sext_q <= sext_d;
      hit_q  <= hit_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Lane select and extension from the captured read word.
  // ---------------------------------------------------------------------------
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] fresh_rdata;

  always_comb begin
    case (lane_q)
      2'd0:    byte_sel = rd_word_q[7:0];
      2'd1:    byte_sel = rd_word_q[15:8];
      2'd2:    byte_sel = rd_word_q[23:16];
      default: byte_sel = rd_word_q[31:24];
    endcase
    half_sel = lane_q[1] ? rd_word_q[31:16] : rd_word_q[15:0];

    fresh_rdata = 32'h0000_0000;
    if (ld_q && hit_q) begin
      case (size_q)
        2'b00:   fresh_rdata = {{24{sext_q & byte_sel[7]}}, byte_sel};
        2'b01:   fresh_rdata = {{16{sext_q & half_sel[15]}}, half_sel};
        default: fresh_rdata = rd_word_q;
      endcase
    end
  end

  // Outputs show the fresh result during the response cycle and otherwise
  // replay the last presented response, so a new acceptance from IDLE does
  // not disturb them before its own response.
  logic [31:0] last_rdata_q, last_rdata_d;
  logic        last_err_q, last_err_d;

  always_comb begin
    last_rdata_d = last_rdata_q;
    last_err_d   = last_err_q;
    if (resp_valid) begin
      last_rdata_d = fresh_rdata;
      last_err_d   = err_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_rdata_q <= 32'h0000_0000;
      last_err_q   <= 1'b0;
    end else begin
      last_rdata_q <= last_rdata_d;
      last_err_q   <= last_err_d;
    end
  end

  assign bus.resp_valid = resp_valid;
  assign bus.resp_rdata = resp_valid ? fresh_rdata : last_rdata_q;
  assign bus.resp_err   = resp_valid ? err_q : last_err_q;

  // ---------------------------------------------------------------------------
  // Latency FSM. The counter is loaded with LATENCY-1 and RESP is entered on
  // the edge where it would reach zero, giving exactly LATENCY cycles from
  // acceptance to the response strobe.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE, S_RESP: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_LOAD;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 2'd1;
        if (cnt_q == 2'd1) begin
          state_d = S_RESP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_dm_bhw.sv
// tb_dm_bhw: scoreboard bench for dm_bhw. Three instances (LATENCY 1, 3, 4)
// share clock and reset. Stimulus pushes hand-computed expectations into a
// per-instance queue; a negedge monitor pops and compares on resp_valid,
// including the acceptance-to-response latency.
module tb_dm_bhw;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  dm_bhw_if #(.ADDR_W(14)) if1 ();
  dm_bhw_if #(.ADDR_W(14)) if3 ();
  dm_bhw_if #(.ADDR_W(14)) if4 ();

  dm_bhw #(.ADDR_W(14), .LATENCY(1)) u1 (.clk(clk), .reset(rst), .bus(if1));
  dm_bhw #(.ADDR_W(14), .LATENCY(3)) u3 (.clk(clk), .reset(rst), .bus(if3));
  dm_bhw #(.ADDR_W(14), .LATENCY(4)) u4 (.clk(clk), .reset(rst), .bus(if4));

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
    string       name;
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];
  exp_t q4[$];

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input int sel, input logic v, input logic we, input logic [1:0] size,
                       input logic sext, input logic [13:0] addr, input logic [31:0] wd);
    case (sel)
      1: begin
        if1.req_valid = v; if1.req_we = we; if1.req_size = size;
        if1.req_sext = sext; if1.req_addr = addr; if1.req_wdata = wd;
      end
      3: begin
        if3.req_valid = v; if3.req_we = we; if3.req_size = size;
        if3.req_sext = sext; if3.req_addr = addr; if3.req_wdata = wd;
      end
      default: begin
        if4.req_valid = v; if4.req_we = we; if4.req_size = size;
        if4.req_sext = sext; if4.req_addr = addr; if4.req_wdata = wd;
      end
    endcase
  endtask

  function automatic logic rdy(input int sel);
    case (sel)
      1:       return if1.req_ready;
      3:       return if3.req_ready;
      default: return if4.req_ready;
    endcase
  endfunction

  // Must be called in the posedge+#1 phase (or with valid already held while
  // ready is low) so the acceptance edge is the one after the next negedge.
  task automatic req(input int sel, input string nm, input logic we, input logic [1:0] size,
                     input logic sext, input logic [13:0] addr, input logic [31:0] wd,
                     input logic [31:0] er, input logic ee, output int acc);
    exp_t e;
    int n;
    drive(sel, 1'b1, we, size, sext, addr, wd);
    n = 0;
    @(negedge clk);
    while (!rdy(sel) && n < 40) begin
      n++;
      @(negedge clk);
    end
    if (!rdy(sel)) begin
      checks++;
      errors++;
      $display("FAIL %s accept_timeout: req_ready stayed 0, required 1 within 40 cycles", nm);
      acc = -1;
      drive(sel, 1'b0, 1'b0, 2'b00, 1'b0, 14'h0, 32'h0);
    end else begin
      acc     = cyc + 1;
      e.rdata = er;
      e.err   = ee;
      e.acc   = acc;
      e.name  = nm;
      case (sel)
        1:       q1.push_back(e);
        3:       q3.push_back(e);
        default: q4.push_back(e);
      endcase
      @(posedge clk);
      #1;
      drive(sel, 1'b0, 1'b0, 2'b00, 1'b0, 14'h0, 32'h0);
    end
  endtask

  task automatic ld(input int sel, input string nm, input logic [1:0] size, input logic sext,
                    input logic [13:0] addr, input logic [31:0] er, output int acc);
    req(sel, nm, 1'b0, size, sext, addr, 32'h0, er, 1'b0, acc);
  endtask

  task automatic st(input int sel, input string nm, input logic [1:0] size,
                    input logic [13:0] addr, input logic [31:0] wd, output int acc);
    req(sel, nm, 1'b1, size, 1'b0, addr, wd, 32'h0, 1'b0, acc);
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  task automatic mon(input int sel, input logic [31:0] rd, input logic er, input int lat);
    exp_t e;
    bit have;
    have = 1'b0;
    case (sel)
      1:       if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
      3:       if (q3.size() > 0) begin e = q3.pop_front(); have = 1'b1; end
      default: if (q4.size() > 0) begin e = q4.pop_front(); have = 1'b1; end
    endcase
    if (!have) begin
      checks++;
      errors++;
      $display("FAIL unexpected_resp L%0d: got resp_valid=1 rdata=%h err=%b, expected no response",
               lat, rd, er);
    end else begin
      $display("txn L%0d %s: rdata=%h err=%b latency=%0d", lat, e.name, rd, er, cyc - e.acc + 1);
      cmp({e.name, "_rdata"}, rd, e.rdata);
      cmp({e.name, "_err"}, {31'h0, er}, {31'h0, e.err});
      cmp({e.name, "_latency"}, 32'(cyc - e.acc + 1), 32'(lat));
    end
  endtask

  always @(negedge clk) begin
    if (if1.resp_valid === 1'b1) mon(1, if1.resp_rdata, if1.resp_err, 1);
    if (if3.resp_valid === 1'b1) mon(3, if3.resp_rdata, if3.resp_err, 3);
    if (if4.resp_valid === 1'b1) mon(4, if4.resp_rdata, if4.resp_err, 4);
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  logic [31:0] vals [8];
  int a, b, prev_acc, n;

  initial begin
    vals[0] = 32'h0000_0001; vals[1] = 32'h8000_0000;
    vals[2] = 32'hFFFF_FFFF; vals[3] = 32'hA5A5_5A5A;
    vals[4] = 32'h1357_9BDF; vals[5] = 32'h2468_ACE0;
    vals[6] = 32'h0F0F_F0F0; vals[7] = 32'hCAFE_BABE;

    rst = 1'b1;
    drive(1, 1'b0, 1'b0, 2'b00, 1'b0, 14'h0, 32'h0);
    drive(3, 1'b0, 1'b0, 2'b00, 1'b0, 14'h0, 32'h0);
    drive(4, 1'b0, 1'b0, 2'b00, 1'b0, 14'h0, 32'h0);

    // Reset state
    sync();
    cmp("rst_ready_l1", {31'h0, if1.req_ready}, 32'h0);
    cmp("rst_ready_l3", {31'h0, if3.req_ready}, 32'h0);
    cmp("rst_ready_l4", {31'h0, if4.req_ready}, 32'h0);
    cmp("rst_resp_valid", {31'h0, if1.resp_valid}, 32'h0);
    cmp("rst_resp_rdata", if1.resp_rdata, 32'h0);
    cmp("rst_resp_err", {31'h0, if1.resp_err}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    cmp("post_rst_ready_l1", {31'h0, if1.req_ready}, 32'h1);
    sync();

    ld(1, "rst_lw_0000", 2'b10, 1'b0, 14'h0000, 32'h0000_0000, a);
    ld(1, "rst_lw_0004", 2'b10, 1'b0, 14'h0004, 32'h0000_0000, a);
    ld(1, "rst_lw_3ffc", 2'b10, 1'b0, 14'h3FFC, 32'h0000_0000, a);

    // Byte/half merge into a word
    st(1, "sw_10", 2'b10, 14'h0010, 32'h1122_3344, a);
    st(1, "sb_12", 2'b00, 14'h0012, 32'hFFFF_FFAB, a);
    st(1, "sh_10", 2'b01, 14'h0010, 32'h0000_BEEF, a);
    ld(1, "lw_10", 2'b10, 1'b0, 14'h0010, 32'h11AB_BEEF, a);

    // Extension
    ld(1, "lb_12",  2'b00, 1'b1, 14'h0012, 32'hFFFF_FFAB, a);
    ld(1, "lbu_12", 2'b00, 1'b0, 14'h0012, 32'h0000_00AB, a);
    ld(1, "lh_10",  2'b01, 1'b1, 14'h0010, 32'hFFFF_BEEF, a);
    ld(1, "lhu_10", 2'b01, 1'b0, 14'h0010, 32'h0000_BEEF, a);
    ld(1, "lh_12",  2'b01, 1'b1, 14'h0012, 32'h0000_11AB, a);
    ld(1, "lb_13",  2'b00, 1'b1, 14'h0013, 32'h0000_0011, a);
    ld(1, "lbu_10", 2'b00, 1'b0, 14'h0010, 32'h0000_00EF, a);

    // Misalignment and illegal size
    req(1, "sw_21_err", 1'b1, 2'b10, 1'b0, 14'h0021, 32'hDEAD_BEEF, 32'h0, 1'b1, a);
    ld(1, "lw_20", 2'b10, 1'b0, 14'h0020, 32'h0000_0000, a);
    req(1, "lh_23_err", 1'b0, 2'b01, 1'b1, 14'h0023, 32'h0, 32'h0, 1'b1, a);
    req(1, "sz11_ld_err", 1'b0, 2'b11, 1'b0, 14'h0020, 32'h0, 32'h0, 1'b1, a);
    req(1, "sz11_st_err", 1'b1, 2'b11, 1'b0, 14'h0020, 32'h5555_5555, 32'h0, 1'b1, a);
    ld(1, "lw_20_after", 2'b10, 1'b0, 14'h0020, 32'h0000_0000, a);

    // Partial stores into never-written words read back zero elsewhere
    st(1, "sb_41", 2'b00, 14'h0041, 32'h0000_005A, a);
    ld(1, "lw_40", 2'b10, 1'b0, 14'h0040, 32'h0000_5A00, a);
    st(1, "sh_3ffe", 2'b01, 14'h3FFE, 32'h0000_1234, a);
    ld(1, "lw_3ffc", 2'b10, 1'b0, 14'h3FFC, 32'h1234_0000, a);

    // LATENCY=1 back-to-back store/load pairs, one acceptance per cycle
    prev_acc = -1;
    for (int i = 0; i < 8; i++) begin
      st(1, $sformatf("b2b_sw%0d", i), 2'b10, 14'(14'h0100 + 4 * i), vals[i], a);
      if (prev_acc >= 0) cmp($sformatf("b2b_gap_st%0d", i), 32'(a - prev_acc), 32'd1);
      prev_acc = a;
      ld(1, $sformatf("b2b_lw%0d", i), 2'b10, 1'b0, 14'(14'h0100 + 4 * i), vals[i], a);
      cmp($sformatf("b2b_gap_ld%0d", i), 32'(a - prev_acc), 32'd1);
      prev_acc = a;
    end

    // LATENCY=3: ready low while waiting, held request accepted in RESP cycle
    sync();
    st(3, "l3_sw_08", 2'b10, 14'h0008, 32'hCAFE_F00D, a);
    drive(3, 1'b1, 1'b0, 2'b10, 1'b0, 14'h0008, 32'h0);
    @(negedge clk);
    cmp("l3_ready_wait1", {31'h0, if3.req_ready}, 32'h0);
    @(negedge clk);
    cmp("l3_ready_wait2", {31'h0, if3.req_ready}, 32'h0);
    ld(3, "l3_lw_08", 2'b10, 1'b0, 14'h0008, 32'hCAFE_F00D, b);
    cmp("l3_accept_in_resp", 32'(b - a), 32'd3);
    ld(3, "l3_lb_0b", 2'b00, 1'b1, 14'h000B, 32'hFFFF_FFCA, a);

    // LATENCY=4 normal operation, then reset two cycles after an acceptance
    st(4, "l4_sw_30", 2'b10, 14'h0030, 32'h1234_5678, a);
    ld(4, "l4_lw_30", 2'b10, 1'b0, 14'h0030, 32'h1234_5678, a);
    ld(4, "l4_inflight", 2'b10, 1'b0, 14'h0030, 32'h1234_5678, a);
    @(posedge clk);
    #1;
    rst = 1'b1;
    // The in-flight response must never appear.
    q1.delete();
    q3.delete();
    q4.delete();
    @(negedge clk);
    cmp("midrst_ready_l4", {31'h0, if4.req_ready}, 32'h0);
    cmp("midrst_resp_valid", {31'h0, if4.resp_valid}, 32'h0);
    sync();
    rst = 1'b0;
    @(negedge clk);
    cmp("post_midrst_ready_l4", {31'h0, if4.req_ready}, 32'h1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      cmp($sformatf("post_midrst_noresp%0d", i), {31'h0, if4.resp_valid}, 32'h0);
    end
    sync();
    ld(4, "l4_lw_30_erased", 2'b10, 1'b0, 14'h0030, 32'h0000_0000, a);
    ld(1, "l1_lw_10_erased", 2'b10, 1'b0, 14'h0010, 32'h0000_0000, a);

    // Drain outstanding responses
    n = 0;
    while ((q1.size() + q3.size() + q4.size()) > 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    if ((q1.size() + q3.size() + q4.size()) > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d responses still pending, expected 0",
               q1.size() + q3.size() + q4.size());
    end
    repeat (2) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
